// File: rtl/regfile_cc_if.sv
// Register-file port bundle: control, addresses and write data in; read data and flags out.
// Combinational pass-through of signals, no storage; no handshake, every cycle is accepted.
// Backpressure: none, the register file never stalls its driver.
interface regfile_cc_if #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 8
);
  localparam int ADDR_W = $clog2(NUM_REGS);

  logic              LD_REG;
  logic              DRMUX;
  logic [ADDR_W-1:0] DR_ADDR;
  logic [ADDR_W-1:0] SR1_ADDR;
  logic [ADDR_W-1:0] SR2_ADDR;
  logic [DATA_W-1:0] BUS;
  logic              LD_CC;
  logic              LD_BEN;
  logic [2:0]        IR_NZP;
  logic [DATA_W-1:0] SR1_out;
  logic [DATA_W-1:0] SR2_out;
  logic              N;
  logic              Z;
  logic              P;
  logic              BEN;
  logic [15:0]       WR_CNT;

  modport master (
    output LD_REG, DRMUX, DR_ADDR, SR1_ADDR, SR2_ADDR, BUS, LD_CC, LD_BEN, IR_NZP,
    input  SR1_out, SR2_out, N, Z, P, BEN, WR_CNT
  );

  modport slave (
    input  LD_REG, DRMUX, DR_ADDR, SR1_ADDR, SR2_ADDR, BUS, LD_CC, LD_BEN, IR_NZP,
    output SR1_out, SR2_out, N, Z, P, BEN, WR_CNT
  );
endinterface

// File: rtl/regfile_cc.sv
// Register file with two async read ports, NZP condition codes, branch-enable latch, write counter.
// Latency: reads 0 cycles from address; writes, CC, BEN and WR_CNT update on the next CLK edge.
// Backpressure: none; REGFILE_BYPASS_EN forwards same-cycle write data onto matching read ports.
module regfile_cc #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 8
) (
  input logic         CLK,
  input logic         RESET,
  regfile_cc_if.slave rf
);
  localparam int ADDR_W = $clog2(NUM_REGS);
  localparam logic [ADDR_W-1:0] LINK_IDX = ADDR_W'(NUM_REGS - 1);

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [ADDR_W-1:0] wr_idx;
  logic [2:0]        nzp_q, nzp_d;
  logic              ben_q, ben_d;
  logic [15:0]       wr_cnt_q, wr_cnt_d;
  logic              cc_n, cc_z;

  assign wr_idx = rf.DRMUX ? LINK_IDX : rf.DR_ADDR;
  assign cc_n   = rf.BUS[DATA_W-1];
  assign cc_z   = (rf.BUS == '0);

  always_comb begin
    nzp_d    = nzp_q;
    ben_d    = ben_q;
    wr_cnt_d = wr_cnt_q;
    if (rf.LD_CC) begin
      nzp_d = {cc_n, cc_z, !cc_n && !cc_z};
    end
    // BEN looks at the flags held before this edge, even if LD_CC fires too.
    if (rf.LD_BEN) begin
      ben_d = |(rf.IR_NZP & nzp_q);
    end
    if (rf.LD_REG && (wr_cnt_q != 16'hFFFF)) begin
      wr_cnt_d = wr_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
      nzp_q    <= 3'b010;
      ben_q    <= 1'b0;
      wr_cnt_q <= 16'd0;
    end else begin
      if (rf.LD_REG) begin
        regs_q[wr_idx] <= rf.BUS;
      end
      nzp_q    <= nzp_d;
      ben_q    <= ben_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

`ifdef REGFILE_BYPASS_EN
  logic rd1_hit, rd2_hit;
  assign rd1_hit    = rf.LD_REG && (rf.SR1_ADDR == wr_idx);
  assign rd2_hit    = rf.LD_REG && (rf.SR2_ADDR == wr_idx);
  assign rf.SR1_out = rd1_hit ? rf.BUS : regs_q[rf.SR1_ADDR];
  assign rf.SR2_out = rd2_hit ? rf.BUS : regs_q[rf.SR2_ADDR];
`else
  assign rf.SR1_out = regs_q[rf.SR1_ADDR];
  assign rf.SR2_out = regs_q[rf.SR2_ADDR];
`endif

  assign rf.N      = nzp_q[2];
  assign rf.Z      = nzp_q[1];
  assign rf.P      = nzp_q[0];
  assign rf.BEN    = ben_q;
  assign rf.WR_CNT = wr_cnt_q;
endmodule

// File: tb/tb_regfile_cc.sv
// Directed bench for regfile_cc: stimulus pushes per-cycle expectations, a negedge monitor checks them.
module tb_regfile_cc;
  logic CLK = 1'b0;
  logic RESET;

  regfile_cc_if #(.DATA_W(16), .NUM_REGS(8)) rf ();

  regfile_cc #(.DATA_W(16), .NUM_REGS(8)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .rf    (rf)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int          step;
    bit          chk_rd;
    logic [15:0] e_sr1;
    logic [15:0] e_sr2;
    bit          chk_st;
    logic [2:0]  e_nzp;
    logic        e_ben;
    logic [15:0] e_cnt;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   step_id = 0;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  task automatic expect_rd_st(input logic [15:0] s1, input logic [15:0] s2,
                              input logic [2:0] nzp, input logic ben, input logic [15:0] cnt);
    exp_t e;
    e.step = step_id; e.chk_rd = 1'b1; e.e_sr1 = s1; e.e_sr2 = s2;
    e.chk_st = 1'b1; e.e_nzp = nzp; e.e_ben = ben; e.e_cnt = cnt;
    sb_q.push_back(e);
    step_id++;
  endtask

  task automatic expect_st(input logic [2:0] nzp, input logic ben, input logic [15:0] cnt);
    exp_t e;
    e.step = step_id; e.chk_rd = 1'b0; e.e_sr1 = '0; e.e_sr2 = '0;
    e.chk_st = 1'b1; e.e_nzp = nzp; e.e_ben = ben; e.e_cnt = cnt;
    sb_q.push_back(e);
    step_id++;
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input bit ld_reg, input bit drmux, input logic [2:0] dr,
                       input logic [15:0] bus, input bit ld_cc, input bit ld_ben,
                       input logic [2:0] nzp, input logic [2:0] a1, input logic [2:0] a2);
    rf.LD_REG = ld_reg; rf.DRMUX = drmux; rf.DR_ADDR = dr; rf.BUS = bus;
    rf.LD_CC = ld_cc; rf.LD_BEN = ld_ben; rf.IR_NZP = nzp;
    rf.SR1_ADDR = a1; rf.SR2_ADDR = a2;
  endtask

  always @(negedge CLK) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      if (e.chk_rd) begin
        n_tests++;
        if (rf.SR1_out !== e.e_sr1) begin
          n_fail++;
          $display("FAIL sr1 step %0d: got %h want %h", e.step, rf.SR1_out, e.e_sr1);
        end
        n_tests++;
        if (rf.SR2_out !== e.e_sr2) begin
          n_fail++;
          $display("FAIL sr2 step %0d: got %h want %h", e.step, rf.SR2_out, e.e_sr2);
        end
      end
      if (e.chk_st) begin
        n_tests++;
        if ({rf.N, rf.Z, rf.P} !== e.e_nzp) begin
          n_fail++;
          $display("FAIL nzp step %0d: got %b want %b", e.step, {rf.N, rf.Z, rf.P}, e.e_nzp);
        end
        n_tests++;
        if (rf.BEN !== e.e_ben) begin
          n_fail++;
          $display("FAIL ben step %0d: got %b want %b", e.step, rf.BEN, e.e_ben);
        end
        n_tests++;
        if (rf.WR_CNT !== e.e_cnt) begin
          n_fail++;
          $display("FAIL wr_cnt step %0d: got %h want %h", e.step, rf.WR_CNT, e.e_cnt);
        end
      end
    end
  end

  initial begin
    RESET = 1'b1;
    drive(0, 0, 3'd0, 16'h0, 0, 0, 3'b000, 3'd0, 3'd0);
    cyc();
    cyc();
    RESET = 1'b0;

    // Reset state on every index, both ports.
    for (int i = 0; i < 8; i++) begin
      drive(0, 0, 3'd0, 16'h0, 0, 0, 3'b000, 3'(i), 3'(7 - i));
      expect_rd_st(16'h0, 16'h0, 3'b010, 1'b0, 16'd0);
      cyc();
    end

    // R3 <= 8001 via DR_ADDR.
    drive(1, 0, 3'd3, 16'h8001, 0, 0, 3'b000, 3'd3, 3'd7);
    expect_rd_st(BYP ? 16'h8001 : 16'h0, 16'h0, 3'b010, 1'b0, 16'd0);
    cyc();
    drive(0, 0, 3'd0, 16'h0, 0, 0, 3'b000, 3'd3, 3'd7);
    expect_rd_st(16'h8001, 16'h0, 3'b010, 1'b0, 16'd1);
    cyc();

    // Link write: DRMUX=1 targets R7, not DR_ADDR=2.
    drive(1, 1, 3'd2, 16'h1234, 0, 0, 3'b000, 3'd2, 3'd7);
    expect_rd_st(16'h0, BYP ? 16'h1234 : 16'h0, 3'b010, 1'b0, 16'd1);
    cyc();
    drive(0, 0, 3'd0, 16'h0, 0, 0, 3'b000, 3'd7, 3'd2);
    expect_rd_st(16'h1234, 16'h0, 3'b010, 1'b0, 16'd2);
    cyc();

    // LD_CC and LD_BEN together: BEN sees old Z.
    drive(0, 0, 3'd0, 16'hFFFF, 1, 1, 3'b100, 3'd3, 3'd7);
    expect_rd_st(16'h8001, 16'h1234, 3'b010, 1'b0, 16'd2);
    cyc();
    drive(0, 0, 3'd0, 16'h0, 0, 1, 3'b100, 3'd3, 3'd7);
    expect_st(3'b100, 1'b0, 16'd2);
    cyc();
    drive(0, 0, 3'd0, 16'h0, 0, 0, 3'b000, 3'd3, 3'd7);
    expect_st(3'b100, 1'b1, 16'd2);
    cyc();

    // Zero and positive CC sources, then BEN masks against P.
    drive(0, 0, 3'd0, 16'h0000, 1, 0, 3'b000, 3'd0, 3'd0);
    expect_st(3'b100, 1'b1, 16'd2);
    cyc();
    drive(0, 0, 3'd0, 16'h0001, 1, 0, 3'b000, 3'd0, 3'd0);
    expect_st(3'b010, 1'b1, 16'd2);
    cyc();
    drive(0, 0, 3'd0, 16'h0, 0, 1, 3'b110, 3'd0, 3'd0);
    expect_st(3'b001, 1'b1, 16'd2);
    cyc();
    drive(0, 0, 3'd0, 16'h0, 0, 1, 3'b011, 3'd0, 3'd0);
    expect_st(3'b001, 1'b0, 16'd2);
    cyc();
    drive(0, 0, 3'd0, 16'h0, 0, 0, 3'b000, 3'd0, 3'd0);
    expect_st(3'b001, 1'b1, 16'd2);
    cyc();

    // Same-cycle write/read on R5, with all three enables in one cycle.
    drive(1, 0, 3'd5, 16'h1111, 0, 0, 3'b000, 3'd3, 3'd5);
    expect_rd_st(16'h8001, BYP ? 16'h1111 : 16'h0, 3'b001, 1'b1, 16'd2);
    cyc();
    drive(1, 0, 3'd5, 16'hABCD, 1, 1, 3'b100, 3'd3, 3'd5);
    expect_rd_st(16'h8001, BYP ? 16'hABCD : 16'h1111, 3'b001, 1'b1, 16'd3);
    cyc();
    drive(0, 0, 3'd0, 16'h0, 0, 0, 3'b000, 3'd5, 3'd5);
    expect_rd_st(16'hABCD, 16'hABCD, 3'b100, 1'b0, 16'd4);
    cyc();

    // Reset wins over a coincident write, CC and BEN load.
    RESET = 1'b1;
    drive(1, 0, 3'd6, 16'h5555, 1, 1, 3'b111, 3'd6, 3'd5);
    expect_st(3'b100, 1'b0, 16'd4);
    cyc();
    RESET = 1'b0;
    drive(0, 0, 3'd0, 16'h0, 0, 0, 3'b000, 3'd6, 3'd5);
    expect_rd_st(16'h0, 16'h0, 3'b010, 1'b0, 16'd0);
    cyc();

    // Counter saturation after 65535 commits.
    for (int i = 0; i < 65535; i++) begin
      drive(1, 0, 3'd1, 16'(i), 0, 0, 3'b000, 3'd2, 3'd0);
      cyc();
    end
    drive(1, 0, 3'd1, 16'h9999, 0, 0, 3'b000, 3'd2, 3'd0);
    expect_rd_st(16'h0, 16'h0, 3'b010, 1'b0, 16'hFFFF);
    cyc();
    drive(0, 0, 3'd0, 16'h0, 0, 0, 3'b000, 3'd1, 3'd2);
    expect_rd_st(16'h9999, 16'h0, 3'b010, 1'b0, 16'hFFFF);
    cyc();

    cyc();
    cyc();
    n_tests++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, want 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
